// File: rtl/usb_tx.sv
// USB full-speed transmitter: SYNC, LSB-first data with bit stuffing, NRZI and EOP, one bit per clk_en.
// Define USB_TX_UNDERRUN_EN to abort an underrun packet with a forced bit-stuff error (else underrun ends the packet).
module usb_tx #(
  parameter int EOP_SE0_BITS = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       clk_en,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  input  logic       tx_last,
  output logic       tx_ready,
  output logic       d_o,
  output logic       se0,
  output logic       oe,
  output logic       active,
  output logic       tx_error
);

  localparam int CW = (EOP_SE0_BITS > 1) ? $clog2(EOP_SE0_BITS) : 1;

  typedef enum logic [2:0] {
    IDLE, SYNC, DATA, EOP_SE0, EOP_J
`ifdef USB_TX_UNDERRUN_EN
    , ABORT
`endif
  } state_t;

  state_t        state_reg, state_next;
  logic [2:0]    bit_idx_reg, bit_idx_next;
  logic [2:0]    ones_reg, ones_next;
  logic [7:0]    shift_reg, shift_next;
  logic          last_reg, last_next;
  logic [CW-1:0] eop_cnt_reg, eop_cnt_next;
  logic          d_o_reg, d_o_next;
  logic          se0_reg, se0_next;
  logic          oe_reg, oe_next;
  logic          active_reg, active_next;
  logic          fetch;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg   <= IDLE;
      bit_idx_reg <= '0;
      ones_reg    <= '0;
      shift_reg   <= '0;
      last_reg    <= 1'b0;
      eop_cnt_reg <= '0;
      d_o_reg     <= 1'b0;
      se0_reg     <= 1'b0;
      oe_reg      <= 1'b0;
      active_reg  <= 1'b0;
    end else begin
      state_reg   <= state_next;
      bit_idx_reg <= bit_idx_next;
      ones_reg    <= ones_next;
      shift_reg   <= shift_next;
      last_reg    <= last_next;
      eop_cnt_reg <= eop_cnt_next;
      d_o_reg     <= d_o_next;
      se0_reg     <= se0_next;
      oe_reg      <= oe_next;
      active_reg  <= active_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    bit_idx_next = bit_idx_reg;
    ones_next    = ones_reg;
    shift_next   = shift_reg;
    last_next    = last_reg;
    eop_cnt_next = eop_cnt_reg;
    d_o_next     = d_o_reg;
    se0_next     = se0_reg;
    oe_next      = oe_reg;
    active_next  = active_reg;
    tx_ready     = 1'b0;
    tx_error     = 1'b0;
    fetch        = 1'b0;
    if (clk_en) begin
      case (state_reg)
        IDLE: begin
          d_o_next     = 1'b0;
          se0_next     = 1'b0;
          oe_next      = 1'b0;
          active_next  = 1'b0;
          ones_next    = '0;
          bit_idx_next = '0;
          eop_cnt_next = '0;
          last_next    = 1'b0;
          // oe_reg still high means this is the release bit after EOP_J: guarantees one idle bit time
          if (tx_valid && !oe_reg) begin
            state_next   = SYNC;
            d_o_next     = 1'b1;
            oe_next      = 1'b1;
            active_next  = 1'b1;
            bit_idx_next = 3'd1;
          end
        end
        SYNC: begin
          if (bit_idx_reg == 3'd7) begin
            ones_next = ones_reg + 3'd1;
            fetch     = 1'b1;
          end else begin
            d_o_next  = ~d_o_reg;
            ones_next = '0;
          end
          bit_idx_next = bit_idx_reg + 3'd1;
        end
        DATA: begin
          if (ones_reg == 3'd6) begin
            d_o_next  = ~d_o_reg;
            ones_next = '0;
          end else begin
            if (shift_reg[bit_idx_reg]) begin
              ones_next = ones_reg + 3'd1;
            end else begin
              d_o_next  = ~d_o_reg;
              ones_next = '0;
            end
            bit_idx_next = bit_idx_reg + 3'd1;
            fetch        = (bit_idx_reg == 3'd7);
          end
        end
        EOP_SE0: begin
          // a stuff bit still owed after the final data bit goes out before SE0
          if (ones_reg == 3'd6) begin
            d_o_next  = ~d_o_reg;
            ones_next = '0;
          end else begin
            se0_next = 1'b1;
            d_o_next = 1'b0;
            if (eop_cnt_reg == CW'(EOP_SE0_BITS - 1)) state_next = EOP_J;
            else eop_cnt_next = eop_cnt_reg + CW'(1);
          end
        end
        EOP_J: begin
          se0_next   = 1'b0;
          d_o_next   = 1'b0;
          state_next = IDLE;
        end
`ifdef USB_TX_UNDERRUN_EN
        ABORT: begin
          ones_next    = '0;
          bit_idx_next = bit_idx_reg + 3'd1;
          if (bit_idx_reg == 3'd7) state_next = EOP_SE0;
        end
`endif
        default: state_next = IDLE;
      endcase

      if (fetch) begin
        if (last_reg) begin
          state_next = EOP_SE0;
        end else if (tx_valid) begin
          tx_ready   = 1'b1;
          shift_next = tx_data;
          last_next  = tx_last;
          state_next = DATA;
        end else begin
`ifdef USB_TX_UNDERRUN_EN
          state_next   = ABORT;
          tx_error     = 1'b1;
          ones_next    = '0;
          bit_idx_next = '0;
`else
          state_next = EOP_SE0;
`endif
        end
      end
    end
  end

  assign d_o    = d_o_reg;
  assign se0    = se0_reg;
  assign oe     = oe_reg;
  assign active = active_reg;

endmodule

// File: tb/tb_usb_tx.sv
// Directed bench for usb_tx: line symbols per bit time (K, J, 0=SE0, I=released) against hand-derived sequences.
module tb_usb_tx;

  logic       clk = 1'b0;
  logic       reset;
  logic       clk_en;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_last;
  logic       tx_ready;
  logic       d_o;
  logic       se0;
  logic       oe;
  logic       active;
  logic       tx_error;

  int n_vec = 0;
  int n_bad = 0;

  logic [7:0] bytes[$];
  bit         last_flag;
  int         idx;
  int         rdy_cnt;
  int         err_cnt;

  always #5 clk = ~clk;

  usb_tx #(.EOP_SE0_BITS(2)) dut (
    .clk      (clk),
    .reset    (reset),
    .clk_en   (clk_en),
    .tx_data  (tx_data),
    .tx_valid (tx_valid),
    .tx_last  (tx_last),
    .tx_ready (tx_ready),
    .d_o      (d_o),
    .se0      (se0),
    .oe       (oe),
    .active   (active),
    .tx_error (tx_error)
  );

  function automatic logic [7:0] line_sym();
    if (!oe) return "I";
    if (se0) return "0";
    return d_o ? "K" : "J";
  endfunction

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_sym(string tag, logic [7:0] obs, logic [7:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %c expected %c", tag, obs, exp);
    end
  endtask

  // One bit time: clk_en for one clock, then a quiet clock to confirm the line holds without clk_en.
  task automatic tick(string tag, logic [7:0] exp_c);
    tx_valid = (idx < bytes.size());
    tx_data  = 8'h00;
    tx_last  = 1'b0;
    if (tx_valid) begin
      tx_data = bytes[idx];
      tx_last = last_flag && (idx == bytes.size() - 1);
    end
    clk_en = 1'b1;
    #1;
    if (tx_ready === 1'b1) begin
      rdy_cnt++;
      idx++;
    end
    if (tx_error === 1'b1) err_cnt++;
    @(negedge clk);
    clk_en = 1'b0;
    check_sym(tag, line_sym(), exp_c);
    check({tag, " active"}, 32'(active), 32'(exp_c != "I"));
    @(negedge clk);
    check_sym({tag, " hold"}, line_sym(), exp_c);
  endtask

  task automatic run(string tag, string exp, int exp_rdy, int exp_err);
    idx     = 0;
    rdy_cnt = 0;
    err_cnt = 0;
    for (int i = 0; i < exp.len(); i++) tick($sformatf("%s[%0d]", tag, i), exp.getc(i));
    check({tag, " tx_ready pulses"}, 32'(rdy_cnt), 32'(exp_rdy));
    check({tag, " tx_error pulses"}, 32'(err_cnt), 32'(exp_err));
  endtask

  initial begin
    string ack;
    string partial;
    reset    = 1'b1;
    clk_en   = 1'b0;
    tx_data  = 8'h00;
    tx_valid = 1'b0;
    tx_last  = 1'b0;
    #1;
    check("reset d_o", 32'(d_o), 0);
    check("reset se0", 32'(se0), 0);
    check("reset oe", 32'(oe), 0);
    check("reset active", 32'(active), 0);
    check("reset tx_ready", 32'(tx_ready), 0);
    check("reset tx_error", 32'(tx_error), 0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    // ACK handshake
    ack = "KJKJKJKKJJKJJKKK00JI";
    bytes = '{8'hD2};
    last_flag = 1'b1;
    run("ack", ack, 1, 0);

    // stuff inside 0xFF, counted from the last SYNC bit
    bytes = '{8'hFF, 8'h00};
    run("stuff", {"KJKJKJKK", "KKKKKJJJJ", "KJKJKJKJ", "00JI"}, 2, 0);

    // final byte ends with six ones: stuff bit precedes SE0
    bytes = '{8'hFC};
    run("stuff_eop", {"KJKJKJKK", "JKKKKKKK", "J", "00JI"}, 1, 0);

    // four bytes back to back, stuff across the 0xC0/0x0F boundary
    bytes = '{8'hC0, 8'h0F, 8'hA5, 8'h5A};
    run("b2b", {"KJKJKJKK", "JKJKJKKK", "KKKKJKJKJ", "JKKJKKJJ", "KKJJJKKJ", "00JI"}, 4, 0);

    // underrun after two bytes without tx_last
    bytes = '{8'h00, 8'h01};
    last_flag = 1'b0;
`ifdef USB_TX_UNDERRUN_EN
    run("underrun", {"KJKJKJKK", "JKJKJKJK", "KJKJKJKJ", "JJJJJJJJ", "00JI"}, 2, 1);
`else
    run("underrun", {"KJKJKJKK", "JKJKJKJK", "KJKJKJKJ", "00JI"}, 2, 0);
`endif

    // reset in the middle of the data byte releases the line at once
    bytes = '{8'hD2};
    last_flag = 1'b1;
    partial = ack.substr(0, 11);
    run("pre_reset", partial, 1, 0);
    #2;
    reset = 1'b1;
    #1;
    check("midreset oe", 32'(oe), 0);
    check("midreset se0", 32'(se0), 0);
    check("midreset d_o", 32'(d_o), 0);
    check("midreset active", 32'(active), 0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    run("post_reset", ack, 1, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
